// File: rtl/id_ex_stage_pkg.sv
// ---------------------------------------------------------------------------
// id_ex_stage_pkg
// Shared definitions for the ID/EX pipeline register and its hazard unit:
// architectural register indices, ALU operation encodings, and the
// instruction words used for bubbles and system calls.
// No ports (package).
// ---------------------------------------------------------------------------
package id_ex_stage_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_V0   = 5'd2;
  localparam logic [4:0] REG_A0   = 5'd4;
  localparam logic [4:0] REG_RA   = 5'd31;

  localparam logic [31:0] INSTR_NOP     = 32'h0000_0000;
  localparam logic [31:0] INSTR_SYSCALL = 32'h0000_000C;

  // reg_write, mem_read, mem_write, mem_to_reg, alu_src, jal + 4-bit alu_op
  localparam int CTRL_W = 10;

  typedef enum logic [3:0] {
    ALU_AND  = 4'd0,
    ALU_OR   = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_XOR  = 4'd3,
    ALU_NOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SUB  = 4'd6,
    ALU_SLT  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9,
    ALU_SLTU = 4'd10,
    ALU_LUI  = 4'd11
  } alu_op_e;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// ---------------------------------------------------------------------------
// id_ex_stage_hazard_detect
// Pure combinational load-use hazard detection and pipeline stall request.
// Ports:
//   ex_mem_read   in   instruction held in EX is a load
//   ex_write_reg  in   destination register of the EX instruction
//   id_rs, id_rt  in   source register fields of the ID instruction
//   id_uses_rt    in   ID instruction reads rt as a source
//   sig_flush     in   branch/jump taken in EX (kills ID, cancels stalls)
//   sig_ex_busy   in   multicycle EX unit busy
//   hz            out  load-use hazard between EX load and ID consumer
//   sig_stall     out  freeze PC and IF/ID this cycle
// ---------------------------------------------------------------------------
module id_ex_stage_hazard_detect
  import id_ex_stage_pkg::*;
(
  input  logic       ex_mem_read,
  input  logic [4:0] ex_write_reg,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       sig_flush,
  input  logic       sig_ex_busy,
  output logic       hz,
  output logic       sig_stall
);

  logic rs_match;
  logic rt_match;

  // A load into $0 never produces a value worth waiting for.
  assign rs_match = (ex_write_reg == id_rs);
  assign rt_match = id_uses_rt & (ex_write_reg == id_rt);
  assign hz       = ex_mem_read & (ex_write_reg != REG_ZERO) & (rs_match | rt_match);

  // A flushed ID instruction is being discarded, so holding it is pointless.
  assign sig_stall = (hz | sig_ex_busy) & ~sig_flush;

endmodule

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register with load-use hazard handling. Captures decoded
// fields on the same edge the register file captures its read data, so the
// operands line up with these outputs. Inserts bubbles on flush or load-use,
// holds while the EX unit is busy, and counts stall cycles and hazard bubbles.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   id_*                     decoded instruction fields from ID
//   sig_* (inputs)           decoded control, flush and EX-busy
//   alu_op                   ALU operation of the ID instruction
//   sig_stall                combinational freeze of PC and IF/ID
//   ex_*                     registered fields presented to EX
//   stall_count              cycles with sig_stall asserted (wrapping)
//   bubble_count             bubbles inserted for load-use (wrapping)
// ---------------------------------------------------------------------------
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter logic [4:0] RA_REG = REG_RA,
  parameter int         CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      id_instr,
  input  logic [31:0]      id_pc_plus4,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       id_rd,
  input  logic             id_uses_rt,
  input  logic             sig_reg_write,
  input  logic             sig_mem_read,
  input  logic             sig_mem_write,
  input  logic             sig_mem_to_reg,
  input  logic             sig_alu_src,
  input  logic             sig_reg_dst,
  input  logic             sig_jal,
  input  logic [3:0]       alu_op,
  input  logic             sig_flush,
  input  logic             sig_ex_busy,
  output logic             sig_stall,
  output logic [31:0]      ex_instr,
  output logic [31:0]      ex_pc_plus4,
  output logic [4:0]       ex_rs,
  output logic [4:0]       ex_rt,
  output logic [4:0]       ex_write_reg,
  output logic             ex_reg_write,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic             ex_mem_to_reg,
  output logic             ex_alu_src,
  output logic             ex_jal,
  output logic [3:0]       ex_alu_op,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] bubble_count
);

  logic       hz;
  logic [4:0] dest_reg;
  logic       load_bubble;
  logic       capture;
  logic       hz_bubble;

  id_ex_stage_hazard_detect u_hazard (
    .ex_mem_read  (ex_mem_read),
    .ex_write_reg (ex_write_reg),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rt   (id_uses_rt),
    .sig_flush    (sig_flush),
    .sig_ex_busy  (sig_ex_busy),
    .hz           (hz),
    .sig_stall    (sig_stall)
  );

  // jal links into $ra; R-type writes rd; I-type writes rt.
  always_comb begin
    dest_reg = id_rt;
    if (sig_jal)
      dest_reg = RA_REG;
    else if (sig_reg_dst)
      dest_reg = id_rd;
  end

  // Update priority: flush, then busy hold, then load-use bubble, then capture.
  always_comb begin
    hz_bubble   = ~sig_flush & ~sig_ex_busy & hz;
    load_bubble = sig_flush | hz_bubble;
    capture     = ~sig_flush & ~sig_ex_busy & ~hz;
  end

  // ---- ID -> EX register boundary ----
  always_ff @(posedge clk) begin
    if (rst || load_bubble) begin
      // A bubble is a full clear: ex_instr becomes a nop, which can never
      // alias syscall, and no write or memory side-effect is enabled.
      ex_instr      <= INSTR_NOP;
      ex_pc_plus4   <= '0;
      ex_rs         <= REG_ZERO;
      ex_rt         <= REG_ZERO;
      ex_write_reg  <= REG_ZERO;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_alu_src    <= 1'b0;
      ex_jal        <= 1'b0;
      ex_alu_op     <= '0;
    end else if (capture) begin
      ex_instr      <= id_instr;
      ex_pc_plus4   <= id_pc_plus4;
      ex_rs         <= id_rs;
      ex_rt         <= id_rt;
      ex_write_reg  <= dest_reg;
      ex_reg_write  <= sig_reg_write;
      ex_mem_read   <= sig_mem_read;
      ex_mem_write  <= sig_mem_write;
      ex_mem_to_reg <= sig_mem_to_reg;
      ex_alu_src    <= sig_alu_src;
      ex_jal        <= sig_jal;
      ex_alu_op     <= alu_op;
    end
  end

  // ---- performance counters ----
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count  <= '0;
      bubble_count <= '0;
    end else begin
      if (sig_stall)
        stall_count <= stall_count + CNT_W'(1);
      if (hz_bubble)
        bubble_count <= bubble_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
// Self-checking bench for id_ex_stage: directed scenarios with literal
// expectations followed by randomized traffic checked against a behavioural
// model of the ID/EX register, hazard rule and counters.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] id_instr, id_pc_plus4;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        id_uses_rt;
  logic        sig_reg_write, sig_mem_read, sig_mem_write, sig_mem_to_reg;
  logic        sig_alu_src, sig_reg_dst, sig_jal;
  logic [3:0]  alu_op;
  logic        sig_flush, sig_ex_busy;
  logic        sig_stall;
  logic [31:0] ex_instr, ex_pc_plus4;
  logic [4:0]  ex_rs, ex_rt, ex_write_reg;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_jal;
  logic [3:0]  ex_alu_op;
  logic [31:0] stall_count, bubble_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.RA_REG(5'd31), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .id_instr(id_instr), .id_pc_plus4(id_pc_plus4),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_uses_rt(id_uses_rt),
    .sig_reg_write(sig_reg_write), .sig_mem_read(sig_mem_read),
    .sig_mem_write(sig_mem_write), .sig_mem_to_reg(sig_mem_to_reg),
    .sig_alu_src(sig_alu_src), .sig_reg_dst(sig_reg_dst), .sig_jal(sig_jal),
    .alu_op(alu_op), .sig_flush(sig_flush), .sig_ex_busy(sig_ex_busy),
    .sig_stall(sig_stall),
    .ex_instr(ex_instr), .ex_pc_plus4(ex_pc_plus4),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_write_reg(ex_write_reg),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_alu_src(ex_alu_src), .ex_jal(ex_jal), .ex_alu_op(ex_alu_op),
    .stall_count(stall_count), .bubble_count(bubble_count)
  );

  // Behavioural model: what EX should currently hold, as a bag of fields.
  typedef struct {
    logic [31:0] instr, pc;
    logic [4:0]  rs, rt, wr;
    logic        rw, mr, mw, m2r, as, jal;
    logic [3:0]  op;
  } ex_t;

  ex_t         m;
  ex_t         empty_ex;
  logic [31:0] m_sc, m_bc;

  function automatic logic m_hz();
    return m.mr && (m.wr != 5'd0) &&
           ((m.wr == id_rs) || (id_uses_rt && (m.wr == id_rt)));
  endfunction

  function automatic logic m_stall();
    return (m_hz() || sig_ex_busy) && !sig_flush;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic compare_all();
    chk("sig_stall",     32'(sig_stall),     32'(m_stall()));
    chk("ex_instr",      ex_instr,           m.instr);
    chk("ex_pc_plus4",   ex_pc_plus4,        m.pc);
    chk("ex_rs",         32'(ex_rs),         32'(m.rs));
    chk("ex_rt",         32'(ex_rt),         32'(m.rt));
    chk("ex_write_reg",  32'(ex_write_reg),  32'(m.wr));
    chk("ex_reg_write",  32'(ex_reg_write),  32'(m.rw));
    chk("ex_mem_read",   32'(ex_mem_read),   32'(m.mr));
    chk("ex_mem_write",  32'(ex_mem_write),  32'(m.mw));
    chk("ex_mem_to_reg", 32'(ex_mem_to_reg), 32'(m.m2r));
    chk("ex_alu_src",    32'(ex_alu_src),    32'(m.as));
    chk("ex_jal",        32'(ex_jal),        32'(m.jal));
    chk("ex_alu_op",     32'(ex_alu_op),     32'(m.op));
    chk("stall_count",   stall_count,        m_sc);
    chk("bubble_count",  bubble_count,       m_bc);
  endtask

  task automatic model_edge();
    ex_t nx;
    nx = m;
    if (rst) begin
      nx = empty_ex; m_sc = 0; m_bc = 0;
    end else begin
      if (m_stall()) m_sc = m_sc + 1;
      if (sig_flush) nx = empty_ex;
      else if (sig_ex_busy) nx = m;
      else if (m_hz()) begin nx = empty_ex; m_bc = m_bc + 1; end
      else begin
        nx.instr = id_instr; nx.pc = id_pc_plus4; nx.rs = id_rs; nx.rt = id_rt;
        nx.wr  = sig_jal ? 5'd31 : (sig_reg_dst ? id_rd : id_rt);
        nx.rw  = sig_reg_write; nx.mr = sig_mem_read; nx.mw = sig_mem_write;
        nx.m2r = sig_mem_to_reg; nx.as = sig_alu_src; nx.jal = sig_jal; nx.op = alu_op;
      end
    end
    m = nx;
  endtask

  // One clock: inputs already set after a negedge; compare, take the edge.
  task automatic cyc();
    #1 compare_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 0; id_instr = 0; id_pc_plus4 = 0; id_rs = 0; id_rt = 0; id_rd = 0;
    id_uses_rt = 0; sig_reg_write = 0; sig_mem_read = 0; sig_mem_write = 0;
    sig_mem_to_reg = 0; sig_alu_src = 0; sig_reg_dst = 0; sig_jal = 0;
    alu_op = 0; sig_flush = 0; sig_ex_busy = 0;
  endtask

  task automatic set_rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    idle();
    id_instr = {6'd0, rs, rt, rd, 5'd0, 6'h21};
    id_pc_plus4 = 32'h0040_0100;
    id_rs = rs; id_rt = rt; id_rd = rd; id_uses_rt = 1;
    sig_reg_dst = 1; sig_reg_write = 1; alu_op = 4'd2;
  endtask

  task automatic set_lw(input logic [4:0] base, input logic [4:0] rt);
    idle();
    id_instr = {6'h23, base, rt, 16'd0};
    id_pc_plus4 = 32'h0040_0200;
    id_rs = base; id_rt = rt; id_rd = 0;
    sig_mem_read = 1; sig_reg_write = 1; sig_mem_to_reg = 1; sig_alu_src = 1; alu_op = 4'd2;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] saved;
    empty_ex = '{instr: 0, pc: 0, rs: 0, rt: 0, wr: 0, rw: 0, mr: 0, mw: 0,
                 m2r: 0, as: 0, jal: 0, op: 0};
    m = empty_ex; m_sc = 0; m_bc = 0;
    idle();
    @(negedge clk);

    // Reset with busy ID inputs for two cycles.
    set_lw(5'd4, 5'd8);
    id_instr = 32'hDEAD_BEEF; id_rd = 5'd7; sig_reg_dst = 1; rst = 1;
    @(posedge clk); model_edge(); @(negedge clk);
    cyc();
    chk("rst_instr", ex_instr, 32'h0);
    chk("rst_wr", 32'(ex_write_reg), 32'h0);
    chk("rst_rw", 32'(ex_reg_write), 32'h0);
    chk("rst_sc", stall_count, 32'h0);
    chk("rst_bc", bubble_count, 32'h0);
    idle();
    #1 chk("rst_stall", 32'(sig_stall), 32'h0);

    // Plain capture: addu $3,$1,$2.
    set_rtype(5'd1, 5'd2, 5'd3);
    cyc();
    chk("plain_wr", 32'(ex_write_reg), 32'd3);
    chk("plain_rw", 32'(ex_reg_write), 32'd1);
    chk("plain_instr", ex_instr, 32'h0022_1821);

    // Load-use: lw $8,0($4) ; addu $9,$8,$5.
    set_lw(5'd4, 5'd8);
    cyc();
    set_rtype(5'd8, 5'd5, 5'd9);
    #1 chk("lu_stall", 32'(sig_stall), 32'd1);
    cyc();
    chk("lu_bub_instr", ex_instr, 32'h0);
    chk("lu_bub_rw", 32'(ex_reg_write), 32'h0);
    chk("lu_bc", bubble_count, 32'd1);
    chk("lu_sc", stall_count, 32'd1);
    #1 chk("lu_release", 32'(sig_stall), 32'd0);
    cyc();
    chk("lu_captured", ex_instr, 32'h0105_4821);
    chk("lu_wr", 32'(ex_write_reg), 32'd9);

    // No false stall: lw $0 then use $0.
    set_lw(5'd4, 5'd0);
    cyc();
    set_rtype(5'd0, 5'd0, 5'd9);
    #1 chk("zero_nostall", 32'(sig_stall), 32'd0);
    cyc();
    // lw $8 then addiu $9,$10,5 (rt not a source).
    set_lw(5'd4, 5'd8);
    cyc();
    idle();
    id_instr = 32'h2549_0005; id_rs = 5'd10; id_rt = 5'd9; id_uses_rt = 0;
    sig_alu_src = 1; sig_reg_write = 1; alu_op = 4'd2;
    #1 chk("imm_nostall", 32'(sig_stall), 32'd0);
    cyc();

    // Flush beats a load-use hazard.
    set_lw(5'd4, 5'd8);
    cyc();
    set_rtype(5'd8, 5'd5, 5'd9);
    sig_flush = 1;
    saved = bubble_count;
    #1 chk("fl_stall", 32'(sig_stall), 32'd0);
    cyc();
    chk("fl_instr", ex_instr, 32'h0);
    chk("fl_bc", bubble_count, saved);

    // Busy hold with jal in EX.
    idle();
    id_instr = 32'h0C00_0010; id_pc_plus4 = 32'h0040_0300; sig_jal = 1; sig_reg_write = 1;
    cyc();
    chk("jal_wr", 32'(ex_write_reg), 32'd31);
    saved = stall_count;
    set_rtype(5'd1, 5'd2, 5'd3);
    sig_ex_busy = 1;
    cyc(); cyc(); cyc();
    chk("busy_wr", 32'(ex_write_reg), 32'd31);
    chk("busy_sc", stall_count, saved + 32'd3);
    sig_ex_busy = 0;
    cyc();
    chk("busy_release", ex_instr, 32'h0022_1821);

    // Reset in the middle of a load-use stall.
    set_lw(5'd4, 5'd8);
    cyc();
    set_rtype(5'd8, 5'd5, 5'd9);
    rst = 1;
    cyc();
    rst = 0;
    #1 chk("rst_mid_stall", 32'(sig_stall), 32'd0);
    cyc();

    // Randomized traffic with small register indices to provoke hazards.
    for (int i = 0; i < 3000; i++) begin
      rst            = ($urandom_range(0, 99) < 2);
      id_instr       = $urandom;
      id_pc_plus4    = $urandom;
      id_rs          = 5'($urandom_range(0, 3));
      id_rt          = 5'($urandom_range(0, 3));
      id_rd          = 5'($urandom_range(0, 31));
      id_uses_rt     = 1'($urandom);
      sig_reg_write  = 1'($urandom);
      sig_mem_read   = ($urandom_range(0, 99) < 40);
      sig_mem_write  = 1'($urandom);
      sig_mem_to_reg = 1'($urandom);
      sig_alu_src    = 1'($urandom);
      sig_reg_dst    = 1'($urandom);
      sig_jal        = ($urandom_range(0, 99) < 10);
      alu_op         = 4'($urandom);
      sig_flush      = ($urandom_range(0, 99) < 10);
      sig_ex_busy    = ($urandom_range(0, 99) < 20);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
